axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder
Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 256-bit memory words.
REQ-002 SHALL have parameter ERR_RESP, default 2'b10, response code for out-of-range beats.
REQ-003 SHALL have port clock input 1 as its single clock; all logic is rising-edge.
REQ-004 SHALL have port reset input 1 as an asynchronous, active-low reset.
REQ-005 SHALL have port io_mem_interface_aw_valid input 1: write address valid.
REQ-006 SHALL have port io_mem_interface_aw_ready output 1: write address accepted.
REQ-007 SHALL have port io_mem_interface_aw_bits_addr input 33: byte address.
REQ-008 SHALL have port io_mem_interface_aw_bits_len input 4: beats minus one.
REQ-009 SHALL have port io_mem_interface_w_valid input 1: write data valid.
REQ-010 SHALL have port io_mem_interface_w_ready output 1: write data accepted.
REQ-011 SHALL have port io_mem_interface_w_bits_data input 256: write beat.
REQ-012 SHALL have port io_mem_interface_w_bits_strb input 32: byte enables.
REQ-013 SHALL have port io_mem_interface_w_bits_last input 1: final write beat.
REQ-014 SHALL have port io_mem_interface_b_valid output 1: write response valid.
REQ-015 SHALL have port io_mem_interface_b_ready input 1: write response taken.
REQ-016 SHALL have port io_mem_interface_b_bits_resp output 2: write response code.
REQ-017 SHALL have port io_mem_interface_ar_valid input 1: read address valid.
REQ-018 SHALL have port io_mem_interface_ar_ready output 1: read address accepted.
REQ-019 SHALL have port io_mem_interface_ar_bits_addr input 33: byte address.
REQ-020 SHALL have port io_mem_interface_ar_bits_len input 4: beats minus one.
REQ-021 SHALL have port io_mem_interface_r_valid output 1: read beat valid.
REQ-022 SHALL have port io_mem_interface_r_ready input 1: read beat taken.
REQ-023 SHALL have port io_mem_interface_r_bits_data output 256: read beat.
REQ-024 SHALL have port io_mem_interface_r_bits_last output 1: final read beat.
REQ-025 SHALL have port io_mem_interface_r_bits_resp output 2: read response code.
Function
REQ-026 SHALL treat every burst as INCR, 32-byte beats; word index = addr[32:5], addr[4:0] ignored; beat k addresses index+k.
REQ-027 SHALL run independent read FSM (R_IDLE, R_DATA) and write FSM (W_IDLE, W_DATA, W_RESP).
REQ-028 SHALL assert ar_ready only in R_IDLE; ar handshake latches index/len, moves to R_DATA; first r_valid the next cycle.
REQ-029 SHALL hold r_data/r_last/r_resp stable while r_valid && !r_ready; advance one beat per r handshake, no bubbles.
REQ-030 SHALL assert r_last on beat len only; handshake of that beat returns to R_IDLE (ar_ready high next cycle).
REQ-031 SHALL return r_data 0 and r_resp ERR_RESP for any beat with index >= DEPTH, else data with resp 2'b00.
REQ-032 SHALL assert aw_ready only in W_IDLE and w_ready only in W_DATA; w beats before aw handshake are stalled.
REQ-033 SHALL write each in-range w beat on its handshake, per-byte under strb; out-of-range beats not written.
REQ-034 SHALL enter W_RESP after beat len handshake, raising b_valid the next cycle; b held until b_ready, then W_IDLE.
REQ-035 SHALL set b_resp ERR_RESP if any beat was out of range or w_last mismatched beat count (early or missing); else 2'b00.
REQ-036 SHALL on w_last mismatch still consume exactly len+1 beats.
REQ-037 SHALL, read and write same word same cycle, return pre-write contents on the read beat; write lands that edge.
REQ-038 SHALL not wrap at DEPTH; index arithmetic is 29-bit, never truncated.
Reset
REQ-039 SHALL on reset low drive aw_ready/w_ready/b_valid/ar_ready/r_valid/r_last 0, resp 2'b00, r_data 0, FSMs idle, any burst aborted.
REQ-040 SHALL leave memory contents uninitialised by reset; aw_ready/ar_ready rise the first cycle after release.
Structure
REQ-041 SHALL place DATA_W=256, ADDR_W=33, STRB_W=32, RESP_OKAY, RESP_SLVERR and FSM state enums in shared package axi_mem_pkg.
REQ-042 SHALL isolate storage in sub-module axi_mem_bram (one write port with byte enables, one read port).
Verification
REQ-043 SHALL test: write addr 0x100 len 1 strb all-ones, then read same -> two beats match, r_last on beat 2, resp 0, b_resp 0.
REQ-044 SHALL test: read addr 0 len 1 with r_ready low 3 cycles -> beat 0 held stable, no beat lost.
REQ-045 SHALL test: write addr (DEPTH-1)*32 len 1 -> b_resp 2'b10, word DEPTH-1 written, nothing else.
REQ-046 SHALL test: write strb 0x0000000F data all-ones over zeros -> readback shows only bytes 0-3 set.
REQ-047 SHALL test: reset low mid read burst -> r_valid 0 immediately, ar_ready 1 one cycle after release.

---
 rtl/axi_mem_pkg.sv | 23 ++
 rtl/axi_mem_bram.sv | 30 +++
 rtl/axi_mem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared widths, response codes and FSM state types for the AXI memory responder.
package axi_mem_pkg;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 33;
  localparam int STRB_W = 32;
  localparam int LEN_W  = 4;
  // Word index is addr[32:5] plus a beat offset; one extra bit keeps index+len from wrapping.
  localparam int IDX_W  = 29;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;
endpackage

// File: rtl/axi_mem_bram.sv
// Word storage: one byte-enabled write port, one asynchronous read port.
// Contents are deliberately not reset.
module axi_mem_bram
  import axi_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Per-byte write under strobe; lands on the clock edge of the w handshake.
  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read is combinational; the responder registers it, so a same-edge write is not seen.
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axi_mem_responder.sv
// AXI-style memory slave: INCR bursts of 32-byte beats, independent read and
// write FSMs, out-of-range beats answered with ERR_RESP.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int         DEPTH    = 64,
  parameter logic [1:0] ERR_RESP = 2'b10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_mem_interface_aw_valid,
  output logic              io_mem_interface_aw_ready,
  input  logic [ADDR_W-1:0] io_mem_interface_aw_bits_addr,
  input  logic [LEN_W-1:0]  io_mem_interface_aw_bits_len,
  input  logic              io_mem_interface_w_valid,
  output logic              io_mem_interface_w_ready,
  input  logic [DATA_W-1:0] io_mem_interface_w_bits_data,
  input  logic [STRB_W-1:0] io_mem_interface_w_bits_strb,
  input  logic              io_mem_interface_w_bits_last,
  output logic              io_mem_interface_b_valid,
  input  logic              io_mem_interface_b_ready,
  output logic [1:0]        io_mem_interface_b_bits_resp,
  input  logic              io_mem_interface_ar_valid,
  output logic              io_mem_interface_ar_ready,
  input  logic [ADDR_W-1:0] io_mem_interface_ar_bits_addr,
  input  logic [LEN_W-1:0]  io_mem_interface_ar_bits_len,
  output logic              io_mem_interface_r_valid,
  input  logic              io_mem_interface_r_ready,
  output logic [DATA_W-1:0] io_mem_interface_r_bits_data,
  output logic              io_mem_interface_r_bits_last,
  output logic [1:0]        io_mem_interface_r_bits_resp
);
  localparam int             MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  // Sub-word address bits carry no meaning for 32-byte beats.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{io_mem_interface_aw_bits_addr[4:0], io_mem_interface_ar_bits_addr[4:0]};

  // ---------------- read side ----------------
  rd_state_t         r_rstate;
  logic [IDX_W-1:0]  r_ridx;     // index of the next beat to fetch
  logic [LEN_W-1:0]  r_rlen;
  logic [LEN_W-1:0]  r_rcnt;     // beat number currently presented
  logic              r_ar_ready;
  logic              r_r_valid;
  logic              r_r_last;
  logic [1:0]        r_r_resp;
  logic [DATA_W-1:0] r_r_data;

  logic              w_ar_fire;
  logic              w_r_fire;
  logic [IDX_W-1:0]  w_ar_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_rd_in;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rd_word;
  logic [1:0]        w_rd_resp;
  logic [LEN_W-1:0]  w_rcnt_nxt;

  assign w_ar_fire  = io_mem_interface_ar_valid && r_ar_ready;
  assign w_r_fire   = r_r_valid && io_mem_interface_r_ready;
  assign w_ar_idx   = {1'b0, io_mem_interface_ar_bits_addr[ADDR_W-1:5]};
  // In idle the fetch is for beat 0 of the incoming burst, otherwise the next beat.
  assign w_rd_idx   = (r_rstate == R_IDLE) ? w_ar_idx : r_ridx;
  assign w_rd_in    = w_rd_idx < DEPTH_IDX;
  assign w_rd_word  = w_rd_in ? w_mem_rdata : '0;
  assign w_rd_resp  = w_rd_in ? RESP_OKAY : ERR_RESP;
  assign w_rcnt_nxt = r_rcnt + 4'd1;

  // Read FSM: fetch beat 0 on ar handshake, then one beat per r handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate   <= R_IDLE;
      r_ridx     <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
      r_ar_ready <= 1'b0;
      r_r_valid  <= 1'b0;
      r_r_last   <= 1'b0;
      r_r_resp   <= RESP_OKAY;
      r_r_data   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_ar_ready <= 1'b1;
          if (w_ar_fire) begin
            r_ar_ready <= 1'b0;
            r_rstate   <= R_DATA;
            r_rlen     <= io_mem_interface_ar_bits_len;
            r_rcnt     <= '0;
            r_ridx     <= w_rd_idx + IDX_W'(1);
            r_r_valid  <= 1'b1;
            r_r_last   <= (io_mem_interface_ar_bits_len == 4'd0);
            r_r_data   <= w_rd_word;
            r_r_resp   <= w_rd_resp;
          end
        end
        R_DATA: begin
          if (w_r_fire) begin
            if (r_r_last) begin
              r_r_valid  <= 1'b0;
              r_r_last   <= 1'b0;
              r_r_resp   <= RESP_OKAY;
              r_ar_ready <= 1'b1;
              r_rstate   <= R_IDLE;
            end else begin
              r_rcnt   <= w_rcnt_nxt;
              r_ridx   <= r_ridx + IDX_W'(1);
              r_r_last <= (w_rcnt_nxt == r_rlen);
              r_r_data <= w_rd_word;
              r_r_resp <= w_rd_resp;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write side ----------------
  wr_state_t        r_wstate;
  logic [IDX_W-1:0] r_widx;      // index of the beat expected next
  logic [LEN_W-1:0] r_wlen;
  logic [LEN_W-1:0] r_wcnt;
  logic             r_werr;      // sticky error across the burst
  logic             r_aw_ready;
  logic             r_w_ready;
  logic             r_b_valid;
  logic [1:0]       r_b_resp;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_wr_in;
  logic w_w_final;
  logic w_beat_err;

  assign w_aw_fire  = io_mem_interface_aw_valid && r_aw_ready;
  assign w_w_fire   = io_mem_interface_w_valid && r_w_ready;
  assign w_wr_in    = r_widx < DEPTH_IDX;
  assign w_w_final  = (r_wcnt == r_wlen);
  // A beat is bad if out of range or its last flag disagrees with the beat count.
  assign w_beat_err = !w_wr_in || (io_mem_interface_w_bits_last != w_w_final);

  // Write FSM: accept address, consume exactly len+1 beats, then hold b until taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate   <= W_IDLE;
      r_widx     <= '0;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_werr     <= 1'b0;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_resp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_aw_ready <= 1'b1;
          if (w_aw_fire) begin
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b1;
            r_wstate   <= W_DATA;
            r_widx     <= {1'b0, io_mem_interface_aw_bits_addr[ADDR_W-1:5]};
            r_wlen     <= io_mem_interface_aw_bits_len;
            r_wcnt     <= '0;
            r_werr     <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_w_fire) begin
            if (w_w_final) begin
              r_w_ready <= 1'b0;
              r_b_valid <= 1'b1;
              r_b_resp  <= (r_werr || w_beat_err) ? ERR_RESP : RESP_OKAY;
              r_wstate  <= W_RESP;
            end else begin
              r_wcnt <= r_wcnt + 4'd1;
              r_widx <= r_widx + IDX_W'(1);
              r_werr <= r_werr || w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (io_mem_interface_b_ready) begin
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_aw_ready <= 1'b1;
            r_wstate   <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  axi_mem_bram #(
    .DEPTH (DEPTH),
    .AW    (MEM_AW)
  ) u_bram (
    .clock   (clock),
    .i_we    (w_w_fire && w_wr_in && (r_wstate == W_DATA)),
    .i_waddr (r_widx[MEM_AW-1:0]),
    .i_wdata (io_mem_interface_w_bits_data),
    .i_wstrb (io_mem_interface_w_bits_strb),
    .i_raddr (w_rd_idx[MEM_AW-1:0]),
    .o_rdata (w_mem_rdata)
  );

  assign io_mem_interface_aw_ready    = r_aw_ready;
  assign io_mem_interface_w_ready     = r_w_ready;
  assign io_mem_interface_b_valid     = r_b_valid;
  assign io_mem_interface_b_bits_resp = r_b_resp;
  assign io_mem_interface_ar_ready    = r_ar_ready;
  assign io_mem_interface_r_valid     = r_r_valid;
  assign io_mem_interface_r_bits_data = r_r_data;
  assign io_mem_interface_r_bits_last = r_r_last;
  assign io_mem_interface_r_bits_resp = r_r_resp;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized self-checking bench for axi_mem_responder against a word-array model.
module tb_axi_mem_responder;
  localparam int         DEPTH = 64;
  localparam logic [1:0] ERR   = 2'b10;

  logic         clock, rst_n;
  logic         aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [32:0]  aw_addr, ar_addr;
  logic [3:0]   aw_len, ar_len;
  logic [255:0] w_data, r_data;
  logic [31:0]  w_strb;
  logic [1:0]   b_resp, r_resp;
  logic         ar_valid, ar_ready, r_valid, r_ready, r_last;

  int checks, errors;

  // Reference memory plus per-burst stimulus / capture buffers.
  logic [255:0] mem_m [DEPTH];
  logic [255:0] wd [16];
  logic [31:0]  ws [16];
  logic         wl [16];
  logic [255:0] rd [16];
  logic [1:0]   rr [16];
  logic         rl [16];
  int           nb;
  logic         b_next;

  axi_mem_responder #(.DEPTH(DEPTH), .ERR_RESP(ERR)) dut (
    .clock(clock), .reset(rst_n),
    .io_mem_interface_aw_valid(aw_valid), .io_mem_interface_aw_ready(aw_ready),
    .io_mem_interface_aw_bits_addr(aw_addr), .io_mem_interface_aw_bits_len(aw_len),
    .io_mem_interface_w_valid(w_valid), .io_mem_interface_w_ready(w_ready),
    .io_mem_interface_w_bits_data(w_data), .io_mem_interface_w_bits_strb(w_strb),
    .io_mem_interface_w_bits_last(w_last),
    .io_mem_interface_b_valid(b_valid), .io_mem_interface_b_ready(b_ready),
    .io_mem_interface_b_bits_resp(b_resp),
    .io_mem_interface_ar_valid(ar_valid), .io_mem_interface_ar_ready(ar_ready),
    .io_mem_interface_ar_bits_addr(ar_addr), .io_mem_interface_ar_bits_len(ar_len),
    .io_mem_interface_r_valid(r_valid), .io_mem_interface_r_ready(r_ready),
    .io_mem_interface_r_bits_data(r_data), .io_mem_interface_r_bits_last(r_last),
    .io_mem_interface_r_bits_resp(r_resp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: apply a burst from wd/ws/wl, return the response the rules demand.
  task automatic model_write(input logic [32:0] addr, input logic [3:0] len, output logic [1:0] resp);
    logic [28:0] idx;
    logic err;
    err = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      idx = {1'b0, addr[32:5]} + 29'(k);
      if (idx < 29'(DEPTH)) begin
        for (int b = 0; b < 32; b++)
          if (ws[k][b]) mem_m[idx][b*8 +: 8] = wd[k][b*8 +: 8];
      end else err = 1'b1;
      if (wl[k] != (k == int'(len))) err = 1'b1;
    end
    resp = err ? ERR : 2'b00;
  endtask

  task automatic exp_beat(input logic [32:0] addr, input int k, output logic [255:0] d, output logic [1:0] r);
    logic [28:0] idx;
    idx = {1'b0, addr[32:5]} + 29'(k);
    if (idx < 29'(DEPTH)) begin d = mem_m[idx]; r = 2'b00; end
    else begin d = '0; r = ERR; end
  endtask

  task automatic set_plain(input int len);
    for (int k = 0; k < 16; k++) begin
      wd[k] = rand256(); ws[k] = '1; wl[k] = (k == len);
    end
  endtask

  // Drive one write burst from wd/ws/wl with random gaps and b backpressure.
  task automatic do_write(input logic [32:0] addr, input logic [3:0] len, output logic [1:0] bresp);
    logic rdy, v;
    int n;
    bresp = 2'bxx;
    aw_addr = addr; aw_len = len; aw_valid = 1'b1; n = 0;
    do begin rdy = aw_ready; tick(); n++; end while (!rdy && n < 200);
    aw_valid = 1'b0;
    if (!rdy) begin checks++; errors++; $display("FAIL aw_timeout addr=%h", addr); end
    for (int k = 0; k <= int'(len); k++) begin
      if ($urandom_range(0, 3) == 0) begin w_valid = 1'b0; tick(); end
      w_valid = 1'b1; w_data = wd[k]; w_strb = ws[k]; w_last = wl[k]; n = 0;
      do begin rdy = w_ready; tick(); n++; end while (!rdy && n < 200);
      if (!rdy) begin checks++; errors++; $display("FAIL w_timeout beat=%0d", k); end
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_next = b_valid;
    repeat ($urandom_range(0, 2)) tick();
    b_ready = 1'b1; n = 0;
    do begin v = b_valid; bresp = b_resp; tick(); n++; end while (!v && n < 200);
    b_ready = 1'b0;
    if (!v) begin checks++; errors++; $display("FAIL b_timeout addr=%h", addr); end
  endtask

  // Drive one read burst, capturing beats into rd/rr/rl.
  task automatic do_read(input logic [32:0] addr, input logic [3:0] len, input bit rand_rdy);
    logic rdy, v, l;
    logic [255:0] d;
    logic [1:0] r;
    int n;
    ar_addr = addr; ar_len = len; ar_valid = 1'b1; n = 0;
    do begin rdy = ar_ready; tick(); n++; end while (!rdy && n < 200);
    ar_valid = 1'b0;
    if (!rdy) begin checks++; errors++; $display("FAIL ar_timeout addr=%h", addr); end
    nb = 0; n = 0;
    while (nb <= int'(len) && n < 500) begin
      r_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      v = r_valid; d = r_data; r = r_resp; l = r_last;
      tick();
      if (v && r_ready) begin rd[nb] = d; rr[nb] = r; rl[nb] = l; nb++; end
      n++;
    end
    r_ready = 1'b0;
    if (nb <= int'(len)) begin checks++; errors++; $display("FAIL r_timeout got=%0d want=%0d", nb, int'(len) + 1); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (ar_ready !== 1'b0) begin errors++; $display("FAIL rst_ar_ready got=%b exp=0", ar_ready); end
    checks++; if (aw_ready !== 1'b0) begin errors++; $display("FAIL rst_aw_ready got=%b exp=0", aw_ready); end
    checks++; if ({w_ready, b_valid, r_valid, r_last} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {w_ready, b_valid, r_valid, r_last}); end
    checks++; if (r_data !== '0 || r_resp !== 2'b00 || b_resp !== 2'b00) begin errors++; $display("FAIL rst_data got=%h/%b/%b exp=0", r_data, r_resp, b_resp); end
    @(negedge clock); rst_n = 1'b1; #1;
    checks++; if (ar_ready !== 1'b0) begin errors++; $display("FAIL rel_before_edge got=%b exp=0", ar_ready); end
    tick();
    checks++; if ({aw_ready, ar_ready} !== 2'b11) begin errors++; $display("FAIL rel_ready got=%b exp=11", {aw_ready, ar_ready}); end
  endtask

  // Fill the whole array with known data so later reads never see uninitialised words.
  task automatic test_init();
    logic [1:0] br, eb;
    for (int i = 0; i < DEPTH / 16; i++) begin
      set_plain(15);
      do_write(33'(i * 16 * 32), 4'd15, br);
      model_write(33'(i * 16 * 32), 4'd15, eb);
      checks++; if (br !== eb) begin errors++; $display("FAIL init_bresp got=%b exp=%b", br, eb); end
    end
  endtask

  task automatic test_basic();
    logic [1:0] br, eb, er;
    logic [255:0] ed;
    set_plain(1);
    do_write(33'h100, 4'd1, br);
    model_write(33'h100, 4'd1, eb);
    checks++; if (br !== 2'b00 || br !== eb) begin errors++; $display("FAIL basic_bresp got=%b exp=%b", br, eb); end
    checks++; if (b_next !== 1'b1) begin errors++; $display("FAIL basic_b_timing got=%b exp=1", b_next); end
    do_read(33'h100, 4'd1, 1'b0);
    checks++; if ({r_valid, ar_ready} !== 2'b01) begin errors++; $display("FAIL basic_after_last got=%b exp=01", {r_valid, ar_ready}); end
    for (int k = 0; k < 2; k++) begin
      exp_beat(33'h100, k, ed, er);
      checks++; if (rd[k] !== ed || rd[k] !== wd[k]) begin errors++; $display("FAIL basic_data k=%0d got=%h exp=%h", k, rd[k], ed); end
      checks++; if (rr[k] !== 2'b00 || rl[k] !== (k == 1)) begin errors++; $display("FAIL basic_resp_last k=%0d got=%b/%b exp=00/%0d", k, rr[k], rl[k], k == 1); end
    end
  endtask

  task automatic test_stall();
    logic [255:0] e0, e1;
    logic [1:0] er;
    exp_beat(33'h0, 0, e0, er);
    exp_beat(33'h0, 1, e1, er);
    ar_addr = 33'h0; ar_len = 4'd1; ar_valid = 1'b1; r_ready = 1'b0;
    tick();
    ar_valid = 1'b0;
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL stall_first_valid got=%b exp=1", r_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (r_valid !== 1'b1 || r_data !== e0 || r_last !== 1'b0) begin errors++; $display("FAIL stall_hold i=%0d got=%b/%h/%b exp=1/%h/0", i, r_valid, r_data, r_last, e0); end
    end
    r_ready = 1'b1;
    tick();
    checks++; if (r_valid !== 1'b1 || r_data !== e1 || r_last !== 1'b1) begin errors++; $display("FAIL stall_beat1 got=%b/%h/%b exp=1/%h/1", r_valid, r_data, r_last, e1); end
    tick();
    r_ready = 1'b0;
    checks++; if ({r_valid, ar_ready} !== 2'b01) begin errors++; $display("FAIL stall_end got=%b exp=01", {r_valid, ar_ready}); end
  endtask

  task automatic test_strb();
    logic [1:0] br, eb;
    set_plain(0); wd[0] = '0;
    do_write(33'hA0, 4'd0, br);
    model_write(33'hA0, 4'd0, eb);
    wd[0] = '1; ws[0] = 32'h0000_000F;
    do_write(33'hA0, 4'd0, br);
    model_write(33'hA0, 4'd0, eb);
    checks++; if (br !== eb) begin errors++; $display("FAIL strb_bresp got=%b exp=%b", br, eb); end
    do_read(33'hA0, 4'd0, 1'b0);
    checks++; if (rd[0] !== {224'b0, 32'hFFFF_FFFF} || rd[0] !== mem_m[5]) begin errors++; $display("FAIL strb_data got=%h", rd[0]); end
  endtask

  task automatic test_oob();
    logic [1:0] br, eb, er;
    logic [255:0] ed;
    set_plain(1);
    do_write(33'((DEPTH - 1) * 32), 4'd1, br);
    model_write(33'((DEPTH - 1) * 32), 4'd1, eb);
    checks++; if (br !== 2'b10 || br !== eb) begin errors++; $display("FAIL oob_bresp got=%b exp=%b", br, eb); end
    for (int i = 0; i < DEPTH / 16; i++) begin
      do_read(33'(i * 16 * 32), 4'd15, 1'b1);
      for (int k = 0; k < 16; k++) begin
        checks++; if (rd[k] !== mem_m[i * 16 + k]) begin errors++; $display("FAIL oob_scan word=%0d got=%h exp=%h", i * 16 + k, rd[k], mem_m[i * 16 + k]); end
      end
    end
    do_read(33'((DEPTH - 1) * 32), 4'd1, 1'b0);
    exp_beat(33'((DEPTH - 1) * 32), 1, ed, er);
    checks++; if (rd[1] !== ed || rr[1] !== er || rr[0] !== 2'b00) begin errors++; $display("FAIL oob_read got=%h/%b/%b exp=%h/%b/00", rd[1], rr[1], rr[0], ed, er); end
    do_read(33'h1_FFFF_FFE0, 4'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd[k] !== '0 || rr[k] !== ERR || rl[k] !== (k == 3)) begin errors++; $display("FAIL top_nowrap k=%0d got=%h/%b/%b", k, rd[k], rr[k], rl[k]); end
    end
  endtask

  task automatic test_last_mismatch();
    logic [1:0] br, eb;
    for (int mode = 0; mode < 2; mode++) begin
      set_plain(3);
      for (int k = 0; k < 16; k++) wl[k] = (mode == 1) ? (k == 1) : 1'b0;
      do_write(33'h200, 4'd3, br);
      model_write(33'h200, 4'd3, eb);
      checks++; if (br !== ERR || br !== eb) begin errors++; $display("FAIL last_mismatch mode=%0d got=%b exp=%b", mode, br, eb); end
      do_read(33'h200, 4'd3, 1'b1);
      for (int k = 0; k < 4; k++) begin
        checks++; if (rd[k] !== mem_m[16 + k]) begin errors++; $display("FAIL mismatch_data mode=%0d k=%0d got=%h exp=%h", mode, k, rd[k], mem_m[16 + k]); end
      end
    end
  endtask

  task automatic test_early_w();
    logic [1:0] br, eb;
    w_valid = 1'b1; w_data = '1; w_strb = '1; w_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL early_w_ready i=%0d got=%b exp=0", i, w_ready); end
    end
    w_valid = 1'b0; w_last = 1'b0;
    set_plain(0);
    do_write(33'h300, 4'd0, br);
    model_write(33'h300, 4'd0, eb);
    checks++; if (br !== eb) begin errors++; $display("FAIL early_w_bresp got=%b exp=%b", br, eb); end
    do_read(33'h300, 4'd0, 1'b0);
    checks++; if (rd[0] !== mem_m[24]) begin errors++; $display("FAIL early_w_data got=%h exp=%h", rd[0], mem_m[24]); end
  endtask

  // Read beat fetched on the same edge a write lands must see the old word.
  task automatic test_same_cycle();
    logic [255:0] old_w, new_w;
    logic [1:0] eb;
    old_w = mem_m[10];
    new_w = rand256();
    aw_addr = 33'h140; aw_len = 4'd0; aw_valid = 1'b1;
    tick();
    aw_valid = 1'b0;
    w_valid = 1'b1; w_data = new_w; w_strb = '1; w_last = 1'b1;
    ar_addr = 33'h140; ar_len = 4'd0; ar_valid = 1'b1; r_ready = 1'b0;
    tick();
    w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
    checks++; if (r_valid !== 1'b1 || r_data !== old_w) begin errors++; $display("FAIL same_cycle_old got=%b/%h exp=1/%h", r_valid, r_data, old_w); end
    r_ready = 1'b1; b_ready = 1'b1;
    checks++; if (b_valid !== 1'b1 || b_resp !== 2'b00) begin errors++; $display("FAIL same_cycle_b got=%b/%b exp=1/00", b_valid, b_resp); end
    tick();
    r_ready = 1'b0; b_ready = 1'b0;
    wd[0] = new_w; ws[0] = '1; wl[0] = 1'b1;
    model_write(33'h140, 4'd0, eb);
    do_read(33'h140, 4'd0, 1'b0);
    checks++; if (rd[0] !== new_w) begin errors++; $display("FAIL same_cycle_new got=%h exp=%h", rd[0], new_w); end
  endtask

  task automatic test_random();
    logic [1:0] br, eb, er;
    logic [255:0] ed;
    logic [32:0] addr;
    logic [3:0] len;
    int idx;
    for (int it = 0; it < 30; it++) begin
      idx  = $urandom_range(0, DEPTH + 3);
      len  = 4'($urandom_range(0, 15));
      addr = {28'(idx), 5'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin
          wd[k] = rand256();
          ws[k] = ($urandom_range(0, 2) == 0) ? '1 : $urandom;
          wl[k] = (k == int'(len));
        end
        if ($urandom_range(0, 5) == 0) wl[$urandom_range(0, 15)] ^= 1'b1;
        do_write(addr, len, br);
        model_write(addr, len, eb);
        checks++; if (br !== eb) begin errors++; $display("FAIL rand_bresp it=%0d got=%b exp=%b", it, br, eb); end
      end else begin
        do_read(addr, len, 1'b1);
        for (int k = 0; k <= int'(len); k++) begin
          exp_beat(addr, k, ed, er);
          checks++; if (rd[k] !== ed || rr[k] !== er || rl[k] !== (k == int'(len))) begin errors++; $display("FAIL rand_read it=%0d k=%0d got=%h/%b/%b exp=%h/%b", it, k, rd[k], rr[k], rl[k], ed, er); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    ar_addr = 33'h0; ar_len = 4'd7; ar_valid = 1'b1; r_ready = 1'b0;
    tick();
    ar_valid = 1'b0; r_ready = 1'b1;
    tick(); tick();
    r_ready = 1'b0;
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL midrd_pre got=%b exp=1", r_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({r_valid, r_last, ar_ready} !== 3'b000) begin errors++; $display("FAIL midrd_async got=%b exp=000", {r_valid, r_last, ar_ready}); end
    tick();
    @(negedge clock); rst_n = 1'b1;
    tick();
    checks++; if ({ar_ready, r_valid} !== 2'b10) begin errors++; $display("FAIL midrd_release got=%b exp=10", {ar_ready, r_valid}); end
    do_read(33'h20, 4'd0, 1'b0);
    checks++; if (rd[0] !== mem_m[1] || rl[0] !== 1'b1) begin errors++; $display("FAIL midrd_after got=%h exp=%h", rd[0], mem_m[1]); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    aw_valid = 1'b0; aw_addr = '0; aw_len = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
    ar_valid = 1'b0; ar_addr = '0; ar_len = '0; r_ready = 1'b0;
    test_reset();
    test_init();
    test_basic();
    test_stall();
    test_strb();
    test_oob();
    test_last_mismatch();
    test_early_w();
    test_same_cycle();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
